fetch_sequencer: RTL

Front-end controller for the MIPS pipeline. Every cycle it drives the load enables and next-PC source select of the PC/NPC registers and the IF/ID and ID/EX bubble controls, from hazard, branch/jump, instruction-memory ready and halt inputs. It holds the PC after reset, latches a branch/jump redirect resolved in ID while the delay-slot fetch is still waiting on memory, and counts front-end stall cycles.

---
 rtl/fetch_seq_pkg.sv | 23 ++
 rtl/sat_counter.sv | 26 ++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared encodings for the fetch front-end: sequencer states and next-PC source selects.
// Single-cycle combinational decode; no flow control of its own.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_HALT    = 2'd3
  } seq_state_e;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Jump outranks branch when ID asserts both.
  function automatic logic [1:0] redirect_sel(input logic jump, input logic branch);
    if (jump)        return PC_SRC_JUMP;
    else if (branch) return PC_SRC_BRANCH;
    else             return PC_SRC_SEQ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; count visible the cycle after an increment.
// Increments are dropped silently once the count reaches all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_n_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) count_d = count_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end controller: PC/NPC load enables, next-PC select and IF/ID, ID/EX bubbles; outputs are combinational.
// Holds fetch on hazard, halt or imem not ready; a redirect seen while fetch cannot complete is parked until it does.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int STALL_CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   branch_signal,
  input  logic                   jump_signal,
  input  logic                   hazard_stall,
  input  logic                   imem_ready,
  input  logic                   halt_req,
  input  logic                   resume,
  output logic                   pc_le,
  output logic                   npc_le,
  output logic [1:0]             pc_source_select,
  output logic                   if_id_le,
  output logic                   if_id_bubble,
  output logic                   id_ex_bubble,
  output logic [1:0]             seq_state,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  seq_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              pend_valid_q, pend_valid_d;
  logic [1:0]        pend_sel_q, pend_sel_d;
  logic [1:0]        live_sel;
  logic              stall_inc;

  assign live_sel = redirect_sel(jump_signal, branch_signal);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_BOOT;
      hold_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_sel_q   <= PC_SRC_SEQ;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      pend_valid_q <= pend_valid_d;
      pend_sel_q   <= pend_sel_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    hold_d           = hold_q;
    pend_valid_d     = pend_valid_q;
    pend_sel_d       = pend_sel_q;
    pc_le            = 1'b0;
    pc_source_select = PC_SRC_SEQ;
    if_id_le         = 1'b1;
    if_id_bubble     = 1'b1;
    id_ex_bubble     = 1'b0;
    stall_inc        = 1'b0;

    case (state_q)
      ST_BOOT: begin
        id_ex_bubble = 1'b1;
        if (hold_q == HOLD_LAST) state_d = ST_RUN;
        else                     hold_d  = hold_q + HOLD_W'(1);
      end

      ST_RUN, ST_MEMWAIT: begin
        if (hazard_stall) begin
          // ID holds the branch/jump and will present it again.
          if_id_le     = 1'b0;
          if_id_bubble = 1'b0;
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
        end else if (halt_req) begin
          if (live_sel != PC_SRC_SEQ) begin
            pend_valid_d = 1'b1;
            pend_sel_d   = live_sel;
          end
          state_d = ST_HALT;
        end else if (!imem_ready) begin
          if (live_sel != PC_SRC_SEQ) begin
            pend_valid_d = 1'b1;
            pend_sel_d   = live_sel;
          end
          stall_inc = 1'b1;
          state_d   = ST_MEMWAIT;
        end else begin
          pc_le            = 1'b1;
          if_id_bubble     = 1'b0;
          pc_source_select = pend_valid_q ? pend_sel_q : live_sel;
          pend_valid_d     = 1'b0;
          state_d          = ST_RUN;
        end
      end

      ST_HALT: begin
        if (live_sel != PC_SRC_SEQ) begin
          pend_valid_d = 1'b1;
          pend_sel_d   = live_sel;
        end
        if (resume) state_d = ST_RUN;
      end

      default: state_d = ST_BOOT;
    endcase
  end

  assign npc_le    = pc_le;
  assign seq_state = state_q;

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk_i   (clk),
    .clr_n_i (reset),
    .inc_i   (stall_inc),
    .count_o (stall_count)
  );

endmodule
